// File: rtl/io_button_in.sv
// io_button_in: two-flop synchroniser, per-bit debounce and sticky rising-edge flags for button pads.
// Optional wake request output enabled by defining IO_BUTTON_WAKE_EN; otherwise wake is tied low.
module io_button_in #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 13,
    parameter int DB_LIMIT = 6000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_pad,
    input  logic             wfi,
    input  logic             rd_clr,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] event_out,
    output logic             wake
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(DB_LIMIT - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, level_q, level_d, event_q, event_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]   = (sync2_q[i] == level_q[i] || cnt_q[i] == LIM) ? '0 : cnt_q[i] + 1'b1;
            level_d[i] = (sync2_q[i] != level_q[i] && cnt_q[i] == LIM) ? sync2_q[i] : level_q[i];
        end
        // a rise on the same cycle as a clear strobe must survive
        event_d = (rd_clr ? '0 : event_q) | (level_d & ~level_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            event_q <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= btn_pad;
            sync2_q <= sync1_q;
            level_q <= level_d;
            event_q <= event_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    assign event_out = event_q;

`ifdef IO_BUTTON_WAKE_EN
    logic wake_q, wake_d;

    always_comb wake_d = wfi & |event_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wake_q <= 1'b0;
        else       wake_q <= wake_d;
    end

    assign wake = wake_q;
`else
    logic unused_wfi;
    assign unused_wfi = wfi;
    assign wake = 1'b0;
`endif
endmodule
